// File: rtl/ofdm_pkg.sv
// Shared types and helpers for the OFDM FFT symbol buffer: bank/FSM encodings and
// the index bit-reversal used when OFDM_FFT_BITREV_EN is defined.
package ofdm_pkg;

  localparam int IQ_W      = 16;
  localparam int N_FFT_DEF = 64;
  localparam int REV_MAX_W = 10;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD}       wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM}       rstate_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [REV_MAX_W-1:0] bitrev(input logic [REV_MAX_W-1:0] v, input int w);
    logic [REV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < REV_MAX_W; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofdm_symbol_ram.sv
// Simple dual-port symbol store, two banks of N_FFT samples addressed as {bank, index},
// with a registered (1-cycle) read port.
module ofdm_symbol_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 7
) (
  input  logic              clock_clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clock_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ofdm_fft_symbol_buffer.sv
// Ping-pong symbol buffer between cyclic-prefix removal and the FFT core.
// Define OFDM_FFT_BITREV_EN to stream each symbol out in bit-reversed index order.
module ofdm_fft_symbol_buffer
  import ofdm_pkg::*;
#(
  parameter int N_FFT  = N_FFT_DEF,
  parameter int DATA_W = 2 * IQ_W,
  parameter int CNT_W  = 16
) (
  input  logic              clock_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] asi_in0_data,
  input  logic              asi_in0_valid,
  output logic              asi_in0_ready,
  input  logic              asi_in0_startofpacket,
  input  logic              asi_in0_endofpacket,
  output logic [DATA_W-1:0] aso_out0_data,
  output logic              aso_out0_valid,
  input  logic              aso_out0_ready,
  output logic              aso_out0_startofpacket,
  output logic              aso_out0_endofpacket,
  output logic              err_short,
  output logic              err_long,
  output logic [CNT_W-1:0]  sym_count
);

  localparam int IW = $clog2(N_FFT);
  localparam int AW = IW + 1;
  localparam logic [IW-1:0] LAST = IW'(N_FFT - 1);

  bank_st_t          bank_st [2];
  logic              wr_bank, iss_bank, rd_bank, run;
  wstate_t           wstate, wstate_nxt;
  rstate_t           rstate, rstate_nxt;
  logic [IW-1:0]     widx, widx_nxt, wr_idx;
  logic [IW-1:0]     iss_idx, iss_idx_nxt, rd_order;
  logic              bank_free, acc, ram_we, w_upd, w_toggle, short_nxt, long_nxt;
  bank_st_t          w_val;
  logic              iss, start_drain, iss_toggle, can_issue, pop, done;
  logic              vld_p1, sop_p1, eop_p1;
  logic [DATA_W-1:0] data_p1;
  logic [DATA_W-1:0] sk_data [2];
  logic [1:0]        sk_sop, sk_eop, sk_cnt;
  logic              sk_wp, sk_rp;

  // Stage p0: write-side acceptance and fill sequencing
  assign bank_free     = (bank_st[wr_bank] == EMPTY) || (bank_st[wr_bank] == FILLING);
  assign asi_in0_ready = run && (bank_free || (wstate == W_DISCARD));
  assign acc           = asi_in0_valid && asi_in0_ready;

  always_comb begin
    wstate_nxt = wstate;
    widx_nxt   = widx;
    wr_idx     = widx;
    ram_we     = 1'b0;
    w_upd      = 1'b0;
    w_val      = EMPTY;
    w_toggle   = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    if (acc) begin
      // A sop while discarding only starts a fill once the write bank is free
      if ((asi_in0_startofpacket && bank_free) || (wstate == W_FILL)) begin
        wr_idx = asi_in0_startofpacket ? '0 : widx;
        ram_we = 1'b1;
        w_upd  = 1'b1;
        if (asi_in0_endofpacket) begin
          wstate_nxt = W_IDLE;
          if (wr_idx == LAST) begin
            w_val    = FULL;
            w_toggle = 1'b1;
          end else begin
            w_val     = EMPTY;
            short_nxt = 1'b1;
          end
        end else if (wr_idx == LAST) begin
          w_val      = FULL;
          w_toggle   = 1'b1;
          long_nxt   = 1'b1;
          wstate_nxt = W_DISCARD;
        end else begin
          w_val      = FILLING;
          widx_nxt   = wr_idx + 1'b1;
          wstate_nxt = W_FILL;
        end
      end else if ((wstate == W_DISCARD) && asi_in0_endofpacket) begin
        wstate_nxt = W_IDLE;
      end
    end
  end

  // Stage p0: read issue, throttled so in-flight plus buffered beats never exceed the skid
  assign pop       = (sk_cnt != 2'd0) && aso_out0_ready;
  assign can_issue = ({1'b0, sk_cnt} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop});
  assign done      = pop && sk_eop[sk_rp];

  always_comb begin
    rstate_nxt  = rstate;
    iss_idx_nxt = iss_idx;
    iss         = 1'b0;
    start_drain = 1'b0;
    iss_toggle  = 1'b0;
    case (rstate)
      R_IDLE: begin
        if ((bank_st[iss_bank] == FULL) && can_issue) begin
          iss         = 1'b1;
          start_drain = 1'b1;
          iss_idx_nxt = iss_idx + 1'b1;
          rstate_nxt  = R_FETCH;
        end
      end
      R_FETCH, R_STREAM: begin
        rstate_nxt = R_STREAM;
        if (can_issue) begin
          iss = 1'b1;
          if (iss_idx == LAST) begin
            iss_idx_nxt = '0;
            iss_toggle  = 1'b1;
            rstate_nxt  = R_IDLE;
          end else begin
            iss_idx_nxt = iss_idx + 1'b1;
          end
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

`ifdef OFDM_FFT_BITREV_EN
  assign rd_order = IW'(bitrev(REV_MAX_W'(iss_idx), IW));
`else
  assign rd_order = iss_idx;
`endif

  ofdm_symbol_ram #(.DATA_W(DATA_W), .AW(AW)) u_ram (
    .clock_clk (clock_clk),
    .wr_en     (ram_we),
    .wr_addr   ({wr_bank, wr_idx}),
    .wr_data   (asi_in0_data),
    .rd_en     (iss),
    .rd_addr   ({iss_bank, rd_order}),
    .rd_data   (data_p1)
  );

  // Stage p1 -> p2: RAM output lands in the 2-entry output skid
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      run        <= 1'b0;
      bank_st[0] <= EMPTY;
      bank_st[1] <= EMPTY;
      wstate     <= W_IDLE;
      widx       <= '0;
      wr_bank    <= 1'b0;
      rstate     <= R_IDLE;
      iss_idx    <= '0;
      iss_bank   <= 1'b0;
      rd_bank    <= 1'b0;
      vld_p1     <= 1'b0;
      sop_p1     <= 1'b0;
      eop_p1     <= 1'b0;
      sk_sop     <= '0;
      sk_eop     <= '0;
      sk_wp      <= 1'b0;
      sk_rp      <= 1'b0;
      sk_cnt     <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      sym_count  <= '0;
    end else begin
      run       <= 1'b1;
      wstate    <= wstate_nxt;
      widx      <= widx_nxt;
      rstate    <= rstate_nxt;
      iss_idx   <= iss_idx_nxt;
      err_short <= short_nxt;
      err_long  <= long_nxt;
      if (w_toggle)   wr_bank  <= ~wr_bank;
      if (iss_toggle) iss_bank <= ~iss_bank;
      for (int b = 0; b < 2; b++) begin
        if (w_upd && (wr_bank == 1'(b)))        bank_st[b] <= w_val;
        if (start_drain && (iss_bank == 1'(b))) bank_st[b] <= DRAINING;
        if (done && (rd_bank == 1'(b)))         bank_st[b] <= EMPTY;
      end
      vld_p1 <= iss;
      sop_p1 <= iss && (iss_idx == '0);
      eop_p1 <= iss && (iss_idx == LAST);
      if (vld_p1) begin
        sk_sop[sk_wp] <= sop_p1;
        sk_eop[sk_wp] <= eop_p1;
        sk_wp         <= ~sk_wp;
      end
      if (pop) sk_rp <= ~sk_rp;
      sk_cnt <= sk_cnt + {1'b0, vld_p1} - {1'b0, pop};
      if (done) begin
        rd_bank   <= ~rd_bank;
        sym_count <= sym_count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_clk) begin
    if (vld_p1) sk_data[sk_wp] <= data_p1;
  end

  assign aso_out0_valid         = (sk_cnt != 2'd0);
  assign aso_out0_data          = aso_out0_valid ? sk_data[sk_rp] : '0;
  assign aso_out0_startofpacket = aso_out0_valid && sk_sop[sk_rp];
  assign aso_out0_endofpacket   = aso_out0_valid && sk_eop[sk_rp];

endmodule

// File: tb/tb_ofdm_fft_symbol_buffer.sv
// Self-checking bench for ofdm_fft_symbol_buffer (N_FFT=64); follows OFDM_FFT_BITREV_EN
// for the expected output order.
module tb_ofdm_fft_symbol_buffer;

  localparam int N    = 64;
  localparam int LOGN = 6;

  logic        clock_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [31:0] asi_in0_data = '0;
  logic        asi_in0_valid = 1'b0;
  logic        asi_in0_ready;
  logic        asi_in0_startofpacket = 1'b0;
  logic        asi_in0_endofpacket = 1'b0;
  logic [31:0] aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_ready = 1'b0;
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;
  logic        err_short, err_long;
  logic [15:0] sym_count;

  ofdm_fft_symbol_buffer dut (
    .clock_clk              (clock_clk),
    .reset_reset_n          (reset_reset_n),
    .asi_in0_data           (asi_in0_data),
    .asi_in0_valid          (asi_in0_valid),
    .asi_in0_ready          (asi_in0_ready),
    .asi_in0_startofpacket  (asi_in0_startofpacket),
    .asi_in0_endofpacket    (asi_in0_endofpacket),
    .aso_out0_data          (aso_out0_data),
    .aso_out0_valid         (aso_out0_valid),
    .aso_out0_ready         (aso_out0_ready),
    .aso_out0_startofpacket (aso_out0_startofpacket),
    .aso_out0_endofpacket   (aso_out0_endofpacket),
    .err_short              (err_short),
    .err_long               (err_long),
    .sym_count              (sym_count)
  );

  always #5 clock_clk = ~clock_clk;

  int cyc = 0;
  always @(posedge clock_clk) cyc <= cyc + 1;

  int n_short = 0, n_long = 0, long_cyc = -1;
  always @(negedge clock_clk) begin
    if (err_short) n_short <= n_short + 1;
    if (err_long) begin
      n_long   <= n_long + 1;
      long_cyc <= cyc;
    end
  end

  int compared = 0, mismatched = 0;
  logic [31:0] pkt[$];
  logic [31:0] exp_q[$];
  int          exp_syms = 0;
  logic [31:0] got_d[$];
  logic        got_sop[$];
  logic        got_eop[$];
  int          got_cyc[$];
  int          stab_err, first_vld_cyc, eop_cyc, beat_n_cyc;

  // Output position k carries input sample perm(k) of its symbol
  function automatic int perm(input int k);
    int r, x;
    r = 0;
    x = k;
`ifdef OFDM_FFT_BITREV_EN
    for (int i = 0; i < LOGN; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
`else
    r = x;
`endif
    return r;
  endfunction

  // Reference: a packet of at least N beats yields its first N samples; shorter yields nothing
  task automatic model_pkt();
    if (pkt.size() >= N) begin
      for (int k = 0; k < N; k++) exp_q.push_back(pkt[perm(k)]);
      exp_syms++;
    end
  endtask

  task automatic send_pkt(input int len, input bit idx_data, input int gap_pct);
    bit acc;
    int w;
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(idx_data ? 32'(i) : $urandom());
    model_pkt();
    for (int i = 0; i < len; i++) begin
      asi_in0_valid         = 1'b1;
      asi_in0_data          = pkt[i];
      asi_in0_startofpacket = (i == 0);
      asi_in0_endofpacket   = (i == len - 1);
      acc = 1'b0;
      w   = 0;
      while (!acc) begin
        @(negedge clock_clk);
        acc = asi_in0_ready;
        @(posedge clock_clk);
        #1;
        w++;
        if (!acc && w > 20000) begin
          compared++;
          mismatched++;
          $display("FAIL send_timeout beat %0d: ready never seen, required ready=1", i);
          asi_in0_valid = 1'b0;
          return;
        end
      end
      if (i == N - 1)   beat_n_cyc = cyc;
      if (i == len - 1) eop_cyc    = cyc;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        asi_in0_valid = 1'b0;
        @(posedge clock_clk);
        #1;
      end
    end
    asi_in0_valid         = 1'b0;
    asi_in0_startofpacket = 1'b0;
    asi_in0_endofpacket   = 1'b0;
  endtask

  // Records accepted output beats; also counts any change of a stalled beat
  task automatic collect(input int nbeats, input bit rand_ready, input int budget);
    int w;
    bit prev_stall;
    logic [31:0] pd;
    logic ps, pe;
    got_d.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete();
    stab_err = 0;
    first_vld_cyc = -1;
    prev_stall = 1'b0;
    pd = '0; ps = 1'b0; pe = 1'b0;
    w = 0;
    while (got_d.size() < nbeats && w < budget) begin
      aso_out0_ready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
      @(negedge clock_clk);
      if (aso_out0_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (prev_stall && (!aso_out0_valid || aso_out0_data !== pd ||
                         aso_out0_startofpacket !== ps || aso_out0_endofpacket !== pe))
        stab_err++;
      prev_stall = aso_out0_valid && !aso_out0_ready;
      pd = aso_out0_data; ps = aso_out0_startofpacket; pe = aso_out0_endofpacket;
      if (aso_out0_valid && aso_out0_ready) begin
        got_d.push_back(aso_out0_data);
        got_sop.push_back(aso_out0_startofpacket);
        got_eop.push_back(aso_out0_endofpacket);
        got_cyc.push_back(cyc);
      end
      @(posedge clock_clk);
      #1;
      w++;
    end
    aso_out0_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if ({aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, asi_in0_ready,
         err_short, err_long} !== 6'b0 || aso_out0_data !== 32'd0 || sym_count !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: valid=%b ready=%b data=%h sym=%0d, required all 0",
               aso_out0_valid, asi_in0_ready, aso_out0_data, sym_count);
    end
    repeat (2) @(posedge clock_clk);
    #1;
    reset_reset_n = 1'b1;
    repeat (2) @(posedge clock_clk);
    #1;
    compared++;
    if (asi_in0_ready !== 1'b1 || aso_out0_valid !== 1'b0 || sym_count !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_release: ready=%b valid=%b sym=%0d, required ready=1 valid=0 sym=0",
               asi_in0_ready, aso_out0_valid, sym_count);
    end
  endtask

  task automatic test_single();
    int nf = 0;
    exp_q.delete();
    fork
      send_pkt(N, 1'b1, 0);
      collect(N, 1'b0, 1000);
    join
    compared++;
    if (got_d.size() !== N) begin
      mismatched++;
      $display("FAIL single_count: got %0d beats, required %0d", got_d.size(), N);
    end
    for (int k = 0; k < N; k++) begin
      compared++;
      if (got_d[k] !== exp_q[k] || got_sop[k] !== (k == 0) || got_eop[k] !== (k == N - 1)) begin
        mismatched++;
        if (nf++ < 4) $display("FAIL single_beat[%0d]: d=%h sop=%b eop=%b, required d=%h sop=%b eop=%b",
                               k, got_d[k], got_sop[k], got_eop[k], exp_q[k], k == 0, k == N - 1);
      end
    end
    compared++;
    if (first_vld_cyc - eop_cyc !== 2) begin
      mismatched++;
      $display("FAIL single_latency: %0d cycles, required 2", first_vld_cyc - eop_cyc);
    end
    @(posedge clock_clk);
    #1;
    compared++;
    if (sym_count !== 16'(exp_syms)) begin
      mismatched++;
      $display("FAIL single_symcount: %0d, required %0d", sym_count, exp_syms);
    end
  endtask

  task automatic test_back_to_back();
    int nf = 0;
    exp_q.delete();
    aso_out0_ready = 1'b0;
    send_pkt(N, 1'b0, 0);
    send_pkt(N, 1'b0, 0);
    @(negedge clock_clk);
    compared++;
    if (asi_in0_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_ready_drop: ready=%b, required 0", asi_in0_ready);
    end
    @(posedge clock_clk);
    #1;
    fork
      begin
        send_pkt(N, 1'b0, 0);
        send_pkt(N, 1'b0, 0);
      end
      collect(4 * N, 1'b0, 5000);
    join
    for (int k = 0; k < 4 * N; k++) begin
      compared++;
      if (got_d[k] !== exp_q[k] || got_sop[k] !== (k % N == 0) || got_eop[k] !== (k % N == N - 1)) begin
        mismatched++;
        if (nf++ < 4) $display("FAIL b2b_beat[%0d]: d=%h sop=%b eop=%b, required d=%h",
                               k, got_d[k], got_sop[k], got_eop[k], exp_q[k]);
      end
    end
    for (int p = 0; p < 4; p++) begin
      compared++;
      if (got_cyc[p * N + N - 1] - got_cyc[p * N] !== N - 1) begin
        mismatched++;
        $display("FAIL b2b_gap pkt %0d: span %0d, required %0d", p,
                 got_cyc[p * N + N - 1] - got_cyc[p * N], N - 1);
      end
    end
    compared++;
    if (got_cyc[N] - got_cyc[N - 1] !== 1) begin
      mismatched++;
      $display("FAIL b2b_join: gap %0d cycles between packets 0 and 1, required 1",
               got_cyc[N] - got_cyc[N - 1]);
    end
    @(posedge clock_clk);
    #1;
    compared++;
    if (sym_count !== 16'(exp_syms)) begin
      mismatched++;
      $display("FAIL b2b_symcount: %0d, required %0d", sym_count, exp_syms);
    end
  endtask

  task automatic test_short();
    int nf = 0;
    exp_q.delete();
    n_short = 0; n_long = 0;
    fork
      begin
        send_pkt(40, 1'b0, 0);
        send_pkt(N, 1'b0, 0);
      end
      collect(N, 1'b0, 2000);
    join
    repeat (5) @(posedge clock_clk);
    #1;
    compared++;
    if (n_short !== 1 || n_long !== 0) begin
      mismatched++;
      $display("FAIL short_err: err_short cycles=%0d err_long cycles=%0d, required 1 and 0", n_short, n_long);
    end
    for (int k = 0; k < N; k++) begin
      compared++;
      if (got_d[k] !== exp_q[k] || got_sop[k] !== (k == 0) || got_eop[k] !== (k == N - 1)) begin
        mismatched++;
        if (nf++ < 4) $display("FAIL short_beat[%0d]: d=%h, required d=%h", k, got_d[k], exp_q[k]);
      end
    end
    compared++;
    if (aso_out0_valid !== 1'b0 || sym_count !== 16'(exp_syms)) begin
      mismatched++;
      $display("FAIL short_after: valid=%b sym=%0d, required valid=0 sym=%0d", aso_out0_valid, sym_count, exp_syms);
    end
  endtask

  task automatic test_long();
    int nf = 0, bn = 0;
    exp_q.delete();
    n_short = 0; n_long = 0;
    fork
      begin
        send_pkt(70, 1'b0, 0);
        bn = beat_n_cyc;
        send_pkt(N, 1'b0, 0);
      end
      collect(2 * N, 1'b0, 3000);
    join
    repeat (5) @(posedge clock_clk);
    #1;
    compared++;
    if (n_long !== 1 || n_short !== 0) begin
      mismatched++;
      $display("FAIL long_err: err_long cycles=%0d err_short cycles=%0d, required 1 and 0", n_long, n_short);
    end
    compared++;
    if (long_cyc !== bn) begin
      mismatched++;
      $display("FAIL long_timing: pulse at cycle %0d, required %0d", long_cyc, bn);
    end
    for (int k = 0; k < 2 * N; k++) begin
      compared++;
      if (got_d[k] !== exp_q[k] || got_sop[k] !== (k % N == 0) || got_eop[k] !== (k % N == N - 1)) begin
        mismatched++;
        if (nf++ < 4) $display("FAIL long_beat[%0d]: d=%h, required d=%h", k, got_d[k], exp_q[k]);
      end
    end
    compared++;
    if (aso_out0_valid !== 1'b0 || sym_count !== 16'(exp_syms)) begin
      mismatched++;
      $display("FAIL long_after: valid=%b sym=%0d, required valid=0 sym=%0d", aso_out0_valid, sym_count, exp_syms);
    end
  endtask

  task automatic test_random_stall();
    int nf = 0;
    exp_q.delete();
    fork
      for (int s = 0; s < 100; s++) send_pkt(N, 1'b0, 30);
      collect(100 * N, 1'b1, 60000);
    join
    compared++;
    if (got_d.size() !== 100 * N) begin
      mismatched++;
      $display("FAIL random_count: got %0d beats, required %0d", got_d.size(), 100 * N);
    end
    for (int k = 0; k < 100 * N; k++) begin
      compared++;
      if (got_d[k] !== exp_q[k] || got_sop[k] !== (k % N == 0) || got_eop[k] !== (k % N == N - 1)) begin
        mismatched++;
        if (nf++ < 4) $display("FAIL random_beat[%0d]: d=%h sop=%b eop=%b, required d=%h",
                               k, got_d[k], got_sop[k], got_eop[k], exp_q[k]);
      end
    end
    compared++;
    if (stab_err !== 0) begin
      mismatched++;
      $display("FAIL random_stall_stable: %0d changes while stalled, required 0", stab_err);
    end
    repeat (3) @(posedge clock_clk);
    #1;
    compared++;
    if (sym_count !== 16'(exp_syms)) begin
      mismatched++;
      $display("FAIL random_symcount: %0d, required %0d", sym_count, exp_syms);
    end
  endtask

  task automatic test_reset_mid();
    int nf = 0;
    exp_q.delete();
    aso_out0_ready = 1'b1;
    send_pkt(N, 1'b0, 0);
    repeat (8) @(posedge clock_clk);
    #2;
    reset_reset_n = 1'b0;
    #1;
    compared++;
    if ({aso_out0_valid, aso_out0_startofpacket, aso_out0_endofpacket, asi_in0_ready,
         err_short, err_long} !== 6'b0 || aso_out0_data !== 32'd0 || sym_count !== 16'd0) begin
      mismatched++;
      $display("FAIL midreset_outputs: valid=%b ready=%b data=%h sym=%0d, required all 0",
               aso_out0_valid, asi_in0_ready, aso_out0_data, sym_count);
    end
    exp_q.delete();
    exp_syms = 0;
    repeat (3) @(posedge clock_clk);
    #1;
    reset_reset_n = 1'b1;
    repeat (2) @(posedge clock_clk);
    #1;
    fork
      send_pkt(N, 1'b0, 0);
      collect(N, 1'b0, 1000);
    join
    for (int k = 0; k < N; k++) begin
      compared++;
      if (got_d[k] !== exp_q[k] || got_sop[k] !== (k == 0) || got_eop[k] !== (k == N - 1)) begin
        mismatched++;
        if (nf++ < 4) $display("FAIL midreset_beat[%0d]: d=%h, required d=%h", k, got_d[k], exp_q[k]);
      end
    end
    repeat (5) @(posedge clock_clk);
    #1;
    compared++;
    if (aso_out0_valid !== 1'b0 || sym_count !== 16'd1) begin
      mismatched++;
      $display("FAIL midreset_after: valid=%b sym=%0d, required valid=0 sym=1", aso_out0_valid, sym_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_short();
    test_long();
    test_random_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
